nco_table_ctrl: RTL and testbench

Controller for the NCO's 256×16 dual-port wavetable RAM (`ram256x16`): port 0 write, port 1 read. It loads a full table from a host valid/ready stream into port 0, then plays it back through port 1 using a programmable phase accumulator. It arbitrates the table between loading and playback so the two never overlap. It sits between the host/config interface and the RAM, and replaces the free-running 8-bit address counter.

---
 rtl/nco_pkg.sv | 14 +
 rtl/nco_table_ctrl_if.sv | 15 +
 rtl/nco_phase_acc.sv | 36 +++
 rtl/nco_table_ctrl.sv | 132 +++++++++++++
 tb/tb_nco_table_ctrl.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nco_pkg.sv
// Shared state encoding and default widths for the NCO wavetable controller.
package nco_pkg;

  localparam int NCO_ADDR_W  = 8;
  localparam int NCO_DATA_W  = 16;
  localparam int NCO_PHASE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } nco_state_t;

endpackage

// File: rtl/nco_table_ctrl_if.sv
// Host sample stream feeding the wavetable loader (valid/ready).
interface nco_table_ctrl_if
  import nco_pkg::*;
#(
  parameter int DATA_W = NCO_DATA_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/nco_phase_acc.sv
// Wrapping phase accumulator; clear has priority over enable.
module nco_phase_acc
  import nco_pkg::*;
#(
  parameter int PHASE_W = NCO_PHASE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (enable) begin
      phase_d = phase_q + phase_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/nco_table_ctrl.sv
// Wavetable controller: loads the table from a host stream into RAM port 0,
// then plays it back through port 1 driven by a phase accumulator.
module nco_table_ctrl
  import nco_pkg::*;
#(
  parameter int ADDR_W  = NCO_ADDR_W,
  parameter int DATA_W  = NCO_DATA_W,
  parameter int PHASE_W = NCO_PHASE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  nco_table_ctrl_if.slave    host,
  input  logic               run_en,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic               table_valid,
  output logic               load_done,
  output logic               csb0,
  output logic [ADDR_W-1:0]  addr0,
  output logic [DATA_W-1:0]  din0,
  output logic               csb1,
  output logic [ADDR_W-1:0]  addr1,
  input  logic [DATA_W-1:0]  dout1,
  output logic [DATA_W-1:0]  sample_out,
  output logic               sample_valid
);

  nco_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q;
  logic               s_ready_q, table_valid_q, load_done_q, last_q;
  logic               csb0_q, csb1_q, run_d1_q, sample_valid_q;
  logic [ADDR_W-1:0]  addr0_q;
  logic [DATA_W-1:0]  din0_q, sample_out_q;
  logic [PHASE_W-1:0] phase;
  logic               beat, last_beat, start_load, enter_run, stay_run;
  logic               phase_unused;

  assign beat       = (state_q == LOAD) && host.s_valid && s_ready_q;
  assign last_beat  = beat && (wr_ptr_q == '1);
  assign start_load = (state_q != LOAD) && (state_d == LOAD);
  assign enter_run  = (state_q != RUN) && (state_d == RUN);
  assign stay_run   = (state_q == RUN) && (state_d == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
        end else if (run_en && table_valid_q) begin
          state_d = RUN;
        end
      end
      LOAD: if (last_beat) state_d = IDLE;
      RUN: begin
        if (load_start) begin
          state_d = LOAD;
        end else if (!run_en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      s_ready_q      <= 1'b0;
      table_valid_q  <= 1'b0;
      load_done_q    <= 1'b0;
      last_q         <= 1'b0;
      csb0_q         <= 1'b1;
      addr0_q        <= '0;
      din0_q         <= '0;
      csb1_q         <= 1'b1;
      run_d1_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_out_q   <= '0;
    end else begin
      state_q <= state_d;
      // load_done and table_valid trail the final write by one cycle
      last_q      <= last_beat;
      load_done_q <= last_q;
      if (last_q) table_valid_q <= 1'b1;
      if (last_beat) s_ready_q <= 1'b0;

      csb0_q <= !beat;
      if (beat) begin
        addr0_q  <= wr_ptr_q;
        din0_q   <= host.s_data;
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end

      if (start_load) begin
        s_ready_q     <= 1'b1;
        table_valid_q <= 1'b0;
        wr_ptr_q      <= '0;
      end

      // Any exit from RUN flushes the read pipeline so stale dout1 is never flagged
      csb1_q         <= (state_d != RUN);
      run_d1_q       <= stay_run;
      sample_valid_q <= run_d1_q && (state_d == RUN);
      if (run_d1_q && (state_d == RUN)) sample_out_q <= dout1;
    end
  end

  nco_phase_acc #(.PHASE_W(PHASE_W)) u_phase_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (enter_run),
    .enable    (state_q == RUN),
    .phase_inc (phase_inc),
    .phase     (phase)
  );

  assign phase_unused = ^phase;

  assign host.s_ready = s_ready_q;
  assign table_valid  = table_valid_q;
  assign load_done    = load_done_q;
  assign csb0         = csb0_q;
  assign addr0        = addr0_q;
  assign din0         = din0_q;
  assign csb1         = csb1_q;
  assign addr1        = phase[PHASE_W-1 -: ADDR_W];
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_nco_table_ctrl.sv
// Self-checking bench for nco_table_ctrl with a behavioural dual-port RAM.
module tb_nco_table_ctrl;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          run_en = 1'b0;
  logic [PW-1:0] phase_inc = '0;
  logic          table_valid, load_done, csb0, csb1, sample_valid;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0, dout1, sample_out;

  nco_table_ctrl_if #(.DATA_W(DW)) host ();

  nco_table_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PHASE_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .host         (host),
    .run_en       (run_en),
    .phase_inc    (phase_inc),
    .table_valid  (table_valid),
    .load_done    (load_done),
    .csb0         (csb0),
    .addr0        (addr0),
    .din0         (din0),
    .csb1         (csb1),
    .addr1        (addr1),
    .dout1        (dout1),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Behavioural ram256x16: port 0 write, port 1 registered read
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (!csb0) ram[addr0] <= din0;
    if (!csb1) dout1 <= ram[addr1];
  end

  int n_checks = 0;
  int n_fails  = 0;
  logic [DW-1:0]    mem_model [256];
  logic [AW+DW-1:0] wr_q [$];
  logic [DW-1:0]    rd_q [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_load(input bit throttle, input int pat, input string name);
    int beats;
    int cyc;
    bit acc;
    logic [DW-1:0] d;
    logic [AW+DW-1:0] e;
    wr_q.delete();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    n_checks++;
    if ({host.s_ready, table_valid, sample_valid, csb1} !== 4'b1001) begin
      n_fails++;
      $display("FAIL %s_entry: {s_ready,table_valid,sample_valid,csb1}=%b required 1001", name,
               {host.s_ready, table_valid, sample_valid, csb1});
    end
    beats = 0;
    cyc = 0;
    while (beats < 256 && cyc < 1200) begin
      host.s_valid = throttle ? (cyc % 2 == 0) : 1'b1;
      case (pat)
        0:       d = DW'(beats * 257);
        1:       d = DW'(beats);
        default: d = DW'(65535 - beats * 257);
      endcase
      host.s_data = d;
      acc = host.s_valid && (host.s_ready === 1'b1);
      if (acc) begin
        wr_q.push_back({AW'(beats), d});
        mem_model[beats] = d;
        beats++;
      end
      @(posedge clk); #1;
      n_checks++;
      if (csb0 !== !acc) begin
        n_fails++;
        $display("FAIL %s_csb0: cycle %0d csb0=%b required %b", name, cyc, csb0, !acc);
      end
      if (acc) begin
        e = wr_q.pop_front();
        n_checks++;
        if ({addr0, din0} !== e) begin
          n_fails++;
          $display("FAIL %s_write: addr0/din0=%h/%h required %h/%h", name, addr0, din0,
                   e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
      n_checks++;
      if (csb1 !== 1'b1) begin
        n_fails++;
        $display("FAIL %s_csb1: cycle %0d csb1=%b required 1 during load", name, cyc, csb1);
      end
      @(negedge clk);
      cyc++;
    end
    host.s_valid = 1'b0;
    n_checks++;
    if (beats != 256 || cyc != (throttle ? 511 : 256)) begin
      n_fails++;
      $display("FAIL %s_length: %0d beats in %0d cycles, required 256 in %0d", name, beats, cyc,
               throttle ? 511 : 256);
    end
    n_checks++;
    if ({host.s_ready, load_done} !== 2'b00) begin
      n_fails++;
      $display("FAIL %s_end: {s_ready,load_done}=%b required 00", name, {host.s_ready, load_done});
    end
    @(negedge clk);
    n_checks++;
    if ({load_done, table_valid, csb1} !== 3'b111) begin
      n_fails++;
      $display("FAIL %s_done: {load_done,table_valid,csb1}=%b required 111", name,
               {load_done, table_valid, csb1});
    end
    @(negedge clk);
    n_checks++;
    if ({load_done, host.s_ready, table_valid} !== 3'b001) begin
      n_fails++;
      $display("FAIL %s_after: {load_done,s_ready,table_valid}=%b required 001", name,
               {load_done, host.s_ready, table_valid});
    end
    $display("load %s: %0d beats over %0d cycles", name, beats, cyc);
  endtask

  task automatic run_play(input logic [PW-1:0] inc, input int ncyc, input string name);
    logic [PW-1:0] mph;
    logic [DW-1:0] exp_s;
    logic [DW-1:0] last_s;
    int got;
    rd_q.delete();
    mph = '0;
    last_s = '0;
    got = 0;
    @(negedge clk); phase_inc = inc; run_en = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      n_checks++;
      if (csb1 !== 1'b0 || addr1 !== mph[PW-1 -: AW]) begin
        n_fails++;
        $display("FAIL %s_addr: step %0d csb1/addr1=%b/%h required 0/%h", name, i, csb1, addr1,
                 mph[PW-1 -: AW]);
      end
      rd_q.push_back(mem_model[mph[PW-1 -: AW]]);
      mph = mph + inc;
      n_checks++;
      if (sample_valid !== 1'(i >= 2)) begin
        n_fails++;
        $display("FAIL %s_valid: step %0d sample_valid=%b required %b", name, i, sample_valid,
                 1'(i >= 2));
      end
      if (sample_valid === 1'b1 && rd_q.size() > 0) begin
        exp_s = rd_q.pop_front();
        n_checks++;
        if (sample_out !== exp_s) begin
          n_fails++;
          $display("FAIL %s_sample: step %0d sample_out=%h required %h", name, i, sample_out, exp_s);
        end
        last_s = exp_s;
        got++;
      end
    end
    run_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b0 || csb1 !== 1'b1 || sample_out !== last_s) begin
      n_fails++;
      $display("FAIL %s_stop: valid/csb1/sample_out=%b/%b/%h required 0/1/%h", name, sample_valid,
               csb1, sample_out, last_s);
    end
    rd_q.delete();
    $display("play %s: inc=%h %0d samples", name, inc, got);
  endtask

  task automatic test_reset;
    host.s_valid = 1'b0;
    host.s_data = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({csb0, csb1, addr0, addr1, din0} !== {2'b11, 32'h0}) begin
      n_fails++;
      $display("FAIL reset_ram: csb0/csb1/addr0/addr1/din0=%b/%b/%h/%h/%h required 1/1/0/0/0",
               csb0, csb1, addr0, addr1, din0);
    end
    n_checks++;
    if ({host.s_ready, table_valid, load_done, sample_valid, sample_out} !== 20'h0) begin
      n_fails++;
      $display("FAIL reset_out: ready/tv/done/sv/sample=%b/%b/%b/%b/%h required all 0",
               host.s_ready, table_valid, load_done, sample_valid, sample_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_full_load;
    drive_load(1'b0, 0, "full");
  endtask

  task automatic test_throttled_load;
    drive_load(1'b1, 1, "throttled");
  endtask

  task automatic test_playback;
    run_play(16'h0100, 300, "step1");
  endtask

  task automatic test_fractional;
    run_play(16'h0080, 24, "half");
    run_play(16'hFF00, 24, "down");
  endtask

  task automatic test_abort;
    @(negedge clk); phase_inc = 16'h0100; run_en = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1) begin
      n_fails++;
      $display("FAIL abort_pre: sample_valid=%b required 1 before abort", sample_valid);
    end
    drive_load(1'b0, 2, "abort");
    n_checks++;
    if (csb1 !== 1'b0) begin
      n_fails++;
      $display("FAIL abort_resume: csb1=%b required 0 after load_done with run_en high", csb1);
    end
    run_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      host.s_valid = 1'b1;
      host.s_data = DW'(16'hA500 + i);
      @(negedge clk);
    end
    #2 rst_n = 1'b0; host.s_valid = 1'b0;
    #1;
    n_checks++;
    if ({csb0, csb1, addr0, addr1, din0} !== {2'b11, 32'h0}) begin
      n_fails++;
      $display("FAIL midreset_ram: csb0/csb1/addr0/addr1/din0=%b/%b/%h/%h/%h required 1/1/0/0/0",
               csb0, csb1, addr0, addr1, din0);
    end
    n_checks++;
    if ({host.s_ready, table_valid, load_done, sample_valid, sample_out} !== 20'h0) begin
      n_fails++;
      $display("FAIL midreset_out: ready/tv/done/sv/sample=%b/%b/%b/%b/%h required all 0",
               host.s_ready, table_valid, load_done, sample_valid, sample_out);
    end
    @(negedge clk); rst_n = 1'b1; run_en = 1'b1; phase_inc = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({csb1, sample_valid, table_valid} !== 3'b100) begin
        n_fails++;
        $display("FAIL midreset_norun: cycle %0d {csb1,sample_valid,table_valid}=%b required 100",
                 i, {csb1, sample_valid, table_valid});
      end
    end
    run_en = 1'b0;
    $display("reset mid-load: playback stayed idle");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_throttled_load();
    test_playback();
    test_fractional();
    test_abort();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
